i2c_slave_rx_controller: RTL and testbench
==========================================

// Module: i2c_slave_rx_controller
// PURPOSE
//  Sequences the I2C slave byte reader for master-write transfers.
//  Detects START/STOP, drives the reader's go, assembles its bit stream MSB-first, matches the address, and ACKs/NACKs bytes.
//  Hands received data bytes to the user side via a valid/ready buffer.
//  Sits between the bus pins (scl/sda sampled, sda pull-down enable) and the slave's register/FIFO logic.
// PARAMETERS
//  SLAVE_ADDR  7'h42  7-bit address this slave answers to
//  SYNC_STAGES 2      input synchroniser depth for scl/sda (>=2)
// PORTS
//  clock        in   1  system clock, all logic on rising edge
//  reset        in   1  asynchronous, active-high reset
//  enable       in   1  0: controller held in IDLE, bus ignored
//  scl          in   1  raw I2C clock
//  sda          in   1  raw I2C data
//  sda_pull     out  1  1 = drive SDA low (ACK); 0 = release
//  rd_go        out  1  go to byte reader
//  rd_data      in   1  bit from byte reader, valid with rd_load
//  rd_load      in   1  one-cycle pulse per bit read
//  rd_finish    in   1  one-cycle pulse after the 8th bit
//  rx_data      out  8  received data byte, stable while rx_valid=1
//  rx_valid     out  1  rx_data holds an unconsumed byte
//  rx_ready     in   1  consumer accepts byte when rx_valid&rx_ready
//  addressed    out  1  1 from address ACK until STOP/START
//  overflow     out  1  1-cycle pulse: byte NACKed because buffer full
//  bus_error    out  1  1-cycle pulse: START/STOP inside a byte
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift reg/bit count 0, synchronisers 1.
//  Edges are taken from synchronised scl/sda (previous vs current).
//   START = sda 1->0 while scl 1; STOP = sda 1->0... no: STOP = sda 0->1 while scl 1.
//  FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
//  IDLE: rd_go=0. START -> ADDR.
//  ADDR/DATA: rd_go=1; each rd_load shifts rd_data in at LSB and increments bit count.
//   rd_finish -> compare the byte:
//   ADDR: byte[7:1]==SLAVE_ADDR and byte[0]==0 (write) -> ADDR_ACK(ack=1); otherwise -> IGNORE.
//   DATA: if rx_valid=0, or rx_ready=1 in the same cycle -> load rx_data, rx_valid=1, DATA_ACK(ack=1).
//   Otherwise -> DATA_ACK(ack=0) and pulse overflow.
//  ACK phases (9th clock), rd_go=0:
//   On the first scl fall, sda_pull=ack.
//   Hold through the scl rise; on the next scl fall, release sda_pull.
//   Then go to DATA (ack=1) or IGNORE (ack=0).
//   addressed is set on entry to ADDR_ACK with ack=1.
//  IGNORE: rd_go=0, sda_pull=0; waits for START (-> ADDR) or STOP (-> IDLE).
//  rx_valid clears on the cycle after rx_valid&rx_ready, unless a new byte loads in that cycle.
//  Repeated START in any non-IDLE state -> ADDR.
//   rd_go is forced 0 for at least one cycle so the reader restarts at bit 0.
//   Bit count and shift reg are cleared; addressed is cleared.
//  STOP in any state -> IDLE; addressed=0; sda_pull=0.
//  bus_error pulses if START/STOP occurs in ADDR/DATA with bit count 1..7.
//  Simultaneous rd_finish and START/STOP: START/STOP wins; the byte is discarded.
//  enable=0: next cycle IDLE, rd_go=0, sda_pull=0; rx_valid/rx_data keep their values.
//  Reset mid-transfer: immediate IDLE, sda_pull released asynchronously.
//  Only master-write is supported; a read request (R/W=1) is never ACKed.
// TESTING
//  1. START, addr 0x84 (0x42,W), data 0xA5, STOP, rx_ready=1:
//     -> ACK on both 9th clocks, rx_data=0xA5, rx_valid 1 pulse-wide, addressed 1 then 0.
//  2. Addr 0x86 (wrong addr):
//     -> sda_pull stays 0, IGNORE, no rx_valid; the next START with 0x84 is accepted.
//  3. Addr 0x85 (0x42, R):
//     -> NACK, IGNORE until STOP, addressed stays 0.
//  4. rx_ready=0, two data bytes 0x11, 0x22:
//     -> first byte ACKed, rx_data=0x11; second byte NACKed, overflow pulses once, then IGNORE.
//  5. Repeated START after 3 data bits, then addr 0x84 + 0x5A:
//     -> bus_error pulse, rd_go low >=1 cycle, byte 0x5A received correctly.
//  6. reset asserted while sda_pull=1 during ACK:
//     -> sda_pull 0 immediately, all outputs 0, IDLE.
//     -> After release, STOP during an ACK phase goes straight to IDLE.

Source files
------------

// File: rtl/i2c_slave_rx_controller_if.sv
// Pin-side, byte-reader and user-side signals of the I2C slave receive controller.
// slave: controller view; master: environment view (bus pins, reader, consumer).
interface i2c_slave_rx_controller_if;
    logic       enable;
    logic       scl;
    logic       sda;
    logic       sda_pull;
    logic       rd_go;
    logic       rd_data;
    logic       rd_load;
    logic       rd_finish;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       addressed;
    logic       overflow;
    logic       bus_error;

    modport slave (
        input  enable, scl, sda, rd_data, rd_load, rd_finish, rx_ready,
        output sda_pull, rd_go, rx_data, rx_valid, addressed, overflow, bus_error
    );

    modport master (
        output enable, scl, sda, rd_data, rd_load, rd_finish, rx_ready,
        input  sda_pull, rd_go, rx_data, rx_valid, addressed, overflow, bus_error
    );
endinterface

// File: rtl/i2c_slave_rx_controller.sv
// I2C slave master-write sequencer: START/STOP detect, address match, ACK/NACK, one-byte rx buffer.
// Bus events act SYNC_STAGES+1 cycles after the pin edge; a full buffer NACKs the byte instead of stalling.
module i2c_slave_rx_controller #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input logic                      clock,
    input logic                      reset,
    i2c_slave_rx_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic [7:0]             shreg;
    logic [3:0]             bit_cnt;
    logic                   ack;
    logic                   ack_driven;
    logic                   sda_pull;
    logic                   rd_go;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   addressed;
    logic                   overflow;
    logic                   bus_error;

    logic scl_cur, sda_cur;
    logic start_det, stop_det, scl_fall, mid_byte;

    assign scl_cur = scl_sync[SYNC_STAGES-1];
    assign sda_cur = sda_sync[SYNC_STAGES-1];

    // scl must be high on both samples so a data change at the scl fall is never mistaken for START/STOP
    assign start_det = scl_prev & scl_cur & sda_prev & ~sda_cur;
    assign stop_det  = scl_prev & scl_cur & ~sda_prev & sda_cur;
    assign scl_fall  = scl_prev & ~scl_cur;
    assign mid_byte  = ((state == ADDR) || (state == DATA)) && (bit_cnt != 4'd0) && (bit_cnt < 4'd8);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda};
            scl_prev <= scl_cur;
            sda_prev <= sda_cur;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= 8'd0;
            bit_cnt    <= 4'd0;
            ack        <= 1'b0;
            ack_driven <= 1'b0;
            sda_pull   <= 1'b0;
            rd_go      <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            addressed  <= 1'b0;
            overflow   <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            bus_error <= 1'b0;
            if (rx_valid && bus.rx_ready)
                rx_valid <= 1'b0;

            if (!bus.enable) begin
                state      <= IDLE;
                rd_go      <= 1'b0;
                sda_pull   <= 1'b0;
                addressed  <= 1'b0;
                bit_cnt    <= 4'd0;
                shreg      <= 8'd0;
                ack_driven <= 1'b0;
            end else if (start_det || stop_det) begin
                // bus events beat a coincident rd_finish; rd_go drops so the reader restarts at bit 0
                bus_error  <= mid_byte;
                state      <= start_det ? ADDR : IDLE;
                rd_go      <= 1'b0;
                sda_pull   <= 1'b0;
                addressed  <= 1'b0;
                bit_cnt    <= 4'd0;
                shreg      <= 8'd0;
                ack_driven <= 1'b0;
            end else begin
                case (state)
                    IDLE: rd_go <= 1'b0;
                    ADDR, DATA: begin
                        rd_go <= 1'b1;
                        if (bus.rd_finish) begin
                            rd_go      <= 1'b0;
                            bit_cnt    <= 4'd0;
                            ack_driven <= 1'b0;
                            if (state == ADDR) begin
                                if (shreg == {SLAVE_ADDR, 1'b0}) begin
                                    ack       <= 1'b1;
                                    addressed <= 1'b1;
                                    state     <= ADDR_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (!rx_valid || bus.rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                                ack      <= 1'b1;
                                state    <= DATA_ACK;
                            end else begin
                                ack      <= 1'b0;
                                overflow <= 1'b1;
                                state    <= DATA_ACK;
                            end
                        end else if (bus.rd_load) begin
                            shreg   <= {shreg[6:0], bus.rd_data};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        rd_go <= 1'b0;
                        // first fall opens the 9th clock, second fall closes it
                        if (scl_fall) begin
                            if (!ack_driven) begin
                                sda_pull   <= ack;
                                ack_driven <= 1'b1;
                            end else begin
                                sda_pull   <= 1'b0;
                                ack_driven <= 1'b0;
                                state      <= ack ? DATA : IGNORE;
                            end
                        end
                    end
                    IGNORE: begin
                        rd_go    <= 1'b0;
                        sda_pull <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sda_pull  = sda_pull;
    assign bus.rd_go     = rd_go;
    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.addressed = addressed;
    assign bus.overflow  = overflow;
    assign bus.bus_error = bus_error;
endmodule

// File: tb/tb_i2c_slave_rx_controller.sv
// Bench for i2c_slave_rx_controller: bit-level I2C master plus byte-reader model, queue-based scoreboard.
module tb_i2c_slave_rx_controller;
    localparam int HALF = 6;

    logic clock;
    logic reset;
    logic sda_m;
    logic ack_strobe;
    logic go_low_seen;
    int   checks;
    int   errors;
    int   ovf_cnt;
    int   berr_cnt;
    logic [7:0] exp_rx[$];
    logic       exp_ack[$];
    logic [7:0] exp_b;
    logic       exp_a;

    i2c_slave_rx_controller_if bus();

    i2c_slave_rx_controller #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // open-drain SDA: master and slave can only pull low
    assign bus.sda = sda_m & ~bus.sda_pull;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected actual=%0h required=none", bus.rx_data);
                end else begin
                    exp_b = exp_rx.pop_front();
                    check("rx_data", 32'(bus.rx_data), 32'(exp_b));
                end
            end
            if (ack_strobe) begin
                if (exp_ack.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected actual=%0b required=none", bus.sda_pull);
                end else begin
                    exp_a = exp_ack.pop_front();
                    check("ack_pull", 32'(bus.sda_pull), 32'(exp_a));
                end
            end
            if (bus.overflow)  ovf_cnt++;
            if (bus.bus_error) berr_cnt++;
            if (!bus.rd_go)    go_low_seen = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // master bit plus byte-reader model: the reader only loads while rd_go is high
    task automatic send_bit(input logic b, input logic last, input logic stay_high);
        sda_m = b;
        cyc(HALF);
        bus.scl = 1'b1;
        cyc(2);
        if (bus.rd_go) begin
            bus.rd_data = b;
            bus.rd_load = 1'b1;
            cyc(1);
            bus.rd_load = 1'b0;
            if (last) begin
                bus.rd_finish = 1'b1;
                cyc(1);
                bus.rd_finish = 1'b0;
            end
        end
        if (!stay_high) begin
            cyc(HALF);
            bus.scl = 1'b0;
            cyc(1);
        end
    endtask

    task automatic ack_clock(input logic exp);
        sda_m = 1'b1;
        cyc(HALF);
        bus.scl = 1'b1;
        cyc(HALF / 2);
        exp_ack.push_back(exp);
        ack_strobe = 1'b1;
        cyc(1);
        ack_strobe = 1'b0;
        cyc(HALF / 2);
        bus.scl = 1'b0;
        cyc(1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp);
        for (int i = 7; i >= 0; i--)
            send_bit(b[i], i == 0, 1'b0);
        ack_clock(exp);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        cyc(HALF);
        bus.scl = 1'b1;
        cyc(HALF);
        sda_m = 1'b0;
        cyc(HALF);
        bus.scl = 1'b0;
        cyc(1);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        cyc(HALF);
        bus.scl = 1'b1;
        cyc(HALF);
        sda_m = 1'b1;
        cyc(HALF);
    endtask

    function automatic logic [13:0] out_vec();
        return {bus.sda_pull, bus.rd_go, bus.rx_valid, bus.addressed,
                bus.overflow, bus.bus_error, bus.rx_data};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a84;
        checks = 0; errors = 0; ovf_cnt = 0; berr_cnt = 0;
        ack_strobe = 1'b0; go_low_seen = 1'b0;
        reset = 1'b1; sda_m = 1'b1;
        bus.enable = 1'b1; bus.scl = 1'b1; bus.rd_data = 1'b0;
        bus.rd_load = 1'b0; bus.rd_finish = 1'b0; bus.rx_ready = 1'b1;
        a84 = 8'h84;

        cyc(3);
        check("reset_outputs", 32'(out_vec()), 32'd0);
        reset = 1'b0;
        cyc(5);

        // 1: addressed write of 0xA5 with consumer always ready
        bus_start();
        exp_rx.push_back(8'hA5);
        send_byte(8'h84, 1'b1);
        check("t1_addressed_set", 32'(bus.addressed), 32'd1);
        send_byte(8'hA5, 1'b1);
        bus_stop();
        check("t1_addressed_clr", 32'(bus.addressed), 32'd0);
        check("t1_rx_valid_clr", 32'(bus.rx_valid), 32'd0);

        // 2: wrong address ignored, then a fresh START is accepted
        bus_start();
        send_byte(8'h86, 1'b0);
        check("t2_not_addressed", 32'(bus.addressed), 32'd0);
        send_byte(8'h3C, 1'b0);
        bus_start();
        exp_rx.push_back(8'h3C);
        send_byte(8'h84, 1'b1);
        send_byte(8'h3C, 1'b1);
        bus_stop();

        // 3: read request is never acknowledged
        bus_start();
        send_byte(8'h85, 1'b0);
        check("t3_not_addressed", 32'(bus.addressed), 32'd0);
        send_byte(8'h77, 1'b0);
        bus_stop();

        // 4: full buffer NACKs the second byte
        bus.rx_ready = 1'b0;
        bus_start();
        exp_rx.push_back(8'h11);
        send_byte(8'h84, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        check("t4_overflow_cnt", 32'(ovf_cnt), 32'd1);
        bus_stop();
        check("t4_rx_held", 32'({bus.rx_valid, bus.rx_data}), 32'h111);
        bus.rx_ready = 1'b1;
        cyc(3);

        // 5: repeated START in the middle of a data byte
        bus_start();
        exp_rx.push_back(8'h5A);
        send_byte(8'h84, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        go_low_seen = 1'b0;
        bus_start();
        check("t5_rd_go_dropped", 32'(go_low_seen), 32'd1);
        check("t5_bus_error_cnt", 32'(berr_cnt), 32'd1);
        send_byte(8'h84, 1'b1);
        send_byte(8'h5A, 1'b1);
        bus_stop();

        // 6: reset while the address ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--)
            send_bit(a84[i], i == 0, 1'b0);
        sda_m = 1'b1;
        cyc(HALF);
        bus.scl = 1'b1;
        cyc(2);
        check("t6_ack_driven", 32'(bus.sda_pull), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_pull_async_clr", 32'(bus.sda_pull), 32'd0);
        check("t6_reset_outputs", 32'(out_vec()), 32'd0);
        cyc(2);
        reset = 1'b0;
        cyc(2);
        bus.scl = 1'b0;
        cyc(HALF);

        // STOP inside the address ACK phase
        bus_start();
        for (int i = 7; i >= 1; i--)
            send_bit(a84[i], 1'b0, 1'b0);
        send_bit(a84[0], 1'b1, 1'b1);
        cyc(2);
        check("t6_addressed_in_ack", 32'(bus.addressed), 32'd1);
        sda_m = 1'b1;
        cyc(HALF);
        check("t6_stop_idle", 32'({bus.addressed, bus.sda_pull, bus.rd_go}), 32'd0);
        bus.scl = 1'b0;
        cyc(1);
        send_byte(8'h84, 1'b0);
        bus_stop();

        for (int i = 0; i < 200 && exp_rx.size() != 0; i++)
            cyc(1);
        check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        check("ack_queue_drained", 32'(exp_ack.size()), 32'd0);
        check("overflow_total", 32'(ovf_cnt), 32'd1);
        check("bus_error_total", 32'(berr_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
